rr_arbiter: RTL

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/rr_arbiter_pkg.sv | 27 ++
 rtl/rr_arbiter_pick.sv | 24 ++
 rtl/rr_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter: FSM states,
// requester count, index/counter widths and a one-hot encoder helper.
package rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 4;
  localparam int PTR_W   = 3;
  localparam int HOLD_W  = 4;

  localparam logic [IDX_W-1:0] IDX_NONE = 4'hF;

  // One-hot to binary; IDX_NONE when no bit is set.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = IDX_NONE;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational rotating priority picker: first set req bit at or above ptr,
// wrapping from the top requester back to 0. Zero when nothing is requested.
module rr_pick
  import rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick
);

  logic [PTR_W-1:0] slot;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pick = '0;
    slot = '0;
    // Scan from the farthest offset down so the nearest requester wins last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      slot = ptr + PTR_W'(i);
      if (req[slot]) pick = NUM_REQ'(1) << slot;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, release on done or
// dropped request, and a forced release with timeout pulse after MAX_HOLD cycles.
module rr_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [3:0]         grant_idx,
  output logic               busy,
  output logic               timeout
);

  import rr_arbiter_pkg::*;

  state_e              state, state_nxt;
  logic [PTR_W-1:0]    ptr, ptr_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [NUM_REQ-1:0]  grant_nxt;
  logic                timeout_nxt;
  logic [NUM_REQ-1:0]  pick;
  logic                holder_req;
  logic                hold_limit;

  rr_pick u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick)
  );

  assign grant_idx  = onehot_to_idx(grant);
  assign busy       = (state == GRANT);
  assign holder_req = |(req & grant);
  assign hold_limit = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          grant_nxt = pick;
          hold_nxt  = '0;
        end
      end

      GRANT: begin
        // A normal release wins over a simultaneous hold-limit expiry.
        if (done || !holder_req) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          ptr_nxt   = grant_idx[PTR_W-1:0] + PTR_W'(1);
        end else if (hold_limit) begin
          state_nxt   = IDLE;
          grant_nxt   = '0;
          ptr_nxt     = grant_idx[PTR_W-1:0] + PTR_W'(1);
          hold_nxt    = hold_cnt + HOLD_W'(1);
          timeout_nxt = 1'b1;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state    <= state_nxt;
      grant    <= grant_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      timeout  <= timeout_nxt;
    end
  end

endmodule
